// File: rtl/serdes_shifter_if.sv
// Parallel/serial handshake bundle for serdes_shifter.
// The slave modport is the shifter; the master modport is the datapath that drives it.
interface serdes_shifter_if #(
   parameter int WIDTH = 8,
   parameter int UNIT  = 1
);
   logic             clear;
   logic             msb_first;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx_shift;
   logic [UNIT-1:0]  ser_out;
   logic             tx_busy;
   logic             tx_underrun;
   logic [UNIT-1:0]  ser_in;
   logic             rx_shift;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             rx_overrun;

   modport slave (
      input  clear, msb_first, tx_data, tx_valid, tx_shift, ser_in, rx_shift, rx_ready,
      output tx_ready, ser_out, tx_busy, tx_underrun, rx_data, rx_valid, rx_overrun
   );

   modport master (
      output clear, msb_first, tx_data, tx_valid, tx_shift, ser_in, rx_shift, rx_ready,
      input  tx_ready, ser_out, tx_busy, tx_underrun, rx_data, rx_valid, rx_overrun
   );
endinterface

// File: rtl/serdes_shifter.sv
// Bidirectional serialiser/deserialiser with a double-buffered transmitter.
// TX first unit appears the cycle after accept; RX word is valid the cycle after its last unit.
module serdes_shifter #(
   parameter int              WIDTH    = 8,
   parameter int              UNIT     = 1,
   parameter logic [UNIT-1:0] IDLE_VAL = '1
) (
   input logic             clock,
   input logic             reset,
   serdes_shifter_if.slave bus
);
   localparam int            N    = WIDTH / UNIT;
   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

   tx_state_t        tx_state_q, tx_state_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
   logic             tx_msb_q, tx_msb_d;
   logic             hold_full_q, hold_full_d;
   logic             underrun_q, underrun_d;
   logic             tx_accept, tx_last;

   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
   logic             rx_msb_q, rx_msb_d;
   logic             rx_valid_q, rx_valid_d;
   logic             overrun_q, overrun_d;
   logic             rx_order;
   logic [WIDTH-1:0] rx_next;

   assign tx_accept = bus.tx_valid && !hold_full_q;
   assign tx_last   = (tx_state_q == TX_SHIFT) && bus.tx_shift && (tx_cnt_q == LAST);

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_sh_d     = tx_sh_q;
      hold_d      = hold_q;
      tx_cnt_d    = tx_cnt_q;
      tx_msb_d    = tx_msb_q;
      hold_full_d = hold_full_q;
      underrun_d  = 1'b0;
      if (bus.clear) begin
         tx_state_d  = TX_IDLE;
         tx_sh_d     = '0;
         hold_d      = '0;
         tx_cnt_d    = '0;
         tx_msb_d    = 1'b1;
         hold_full_d = 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               underrun_d = bus.tx_shift;
               if (tx_accept) begin
                  tx_state_d = TX_SHIFT;
                  tx_sh_d    = bus.tx_data;
                  tx_cnt_d   = '0;
                  tx_msb_d   = bus.msb_first;
               end
            end
            TX_SHIFT: begin
               if (tx_last) begin
                  tx_cnt_d = '0;
                  // Refill from the holding buffer first, else take a word arriving this cycle.
                  if (hold_full_q) begin
                     tx_sh_d     = hold_q;
                     tx_msb_d    = bus.msb_first;
                     hold_full_d = 1'b0;
                  end else if (tx_accept) begin
                     tx_sh_d  = bus.tx_data;
                     tx_msb_d = bus.msb_first;
                  end else begin
                     tx_state_d = TX_IDLE;
                  end
               end else begin
                  if (bus.tx_shift) begin
                     tx_sh_d  = tx_msb_q ? (tx_sh_q << UNIT) : (tx_sh_q >> UNIT);
                     tx_cnt_d = tx_cnt_q + CW'(1);
                  end
                  if (tx_accept) begin
                     hold_d      = bus.tx_data;
                     hold_full_d = 1'b1;
                  end
               end
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
   end

   // Bit order is sampled on the first unit of each word and held for the rest of it.
   assign rx_order = (rx_cnt_q == '0) ? bus.msb_first : rx_msb_q;
   assign rx_next  = rx_order ? ((rx_sh_q << UNIT) | WIDTH'(bus.ser_in))
                              : ((rx_sh_q >> UNIT) | (WIDTH'(bus.ser_in) << (WIDTH - UNIT)));

   always_comb begin
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_cnt_d   = rx_cnt_q;
      rx_msb_d   = rx_msb_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (bus.clear) begin
         rx_sh_d    = '0;
         rx_data_d  = '0;
         rx_cnt_d   = '0;
         rx_msb_d   = 1'b1;
         rx_valid_d = 1'b0;
      end else begin
         if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
         end
         if (bus.rx_shift) begin
            rx_sh_d  = rx_next;
            rx_msb_d = rx_order;
            if (rx_cnt_q == LAST) begin
               rx_cnt_d = '0;
               if (!rx_valid_q || bus.rx_ready) begin
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_q  <= TX_IDLE;
         tx_sh_q     <= '0;
         hold_q      <= '0;
         tx_cnt_q    <= '0;
         tx_msb_q    <= 1'b1;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_cnt_q    <= '0;
         rx_msb_q    <= 1'b1;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_sh_q     <= tx_sh_d;
         hold_q      <= hold_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_msb_q    <= tx_msb_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_msb_q    <= rx_msb_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.tx_ready    = !hold_full_q;
   assign bus.tx_busy     = (tx_state_q == TX_SHIFT);
   assign bus.ser_out     = (tx_state_q == TX_IDLE) ? IDLE_VAL
                          : (tx_msb_q ? tx_sh_q[WIDTH-1 -: UNIT] : tx_sh_q[UNIT-1:0]);
   assign bus.tx_underrun = underrun_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.rx_overrun  = overrun_q;
endmodule

// File: tb/tb_serdes_shifter.sv
// Directed bench for serdes_shifter: an 8x1 instance and a 16x4 instance.
module tb_serdes_shifter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   fails  = 0;

   always #5 clock = ~clock;

   serdes_shifter_if #(.WIDTH(8),  .UNIT(1)) a_if ();
   serdes_shifter_if #(.WIDTH(16), .UNIT(4)) b_if ();

   serdes_shifter #(.WIDTH(8), .UNIT(1), .IDLE_VAL(1'b1)) dut_a (
      .clock(clock), .reset(reset), .bus(a_if)
   );
   serdes_shifter #(.WIDTH(16), .UNIT(4), .IDLE_VAL(4'hF)) dut_b (
      .clock(clock), .reset(reset), .bus(b_if)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic init_inputs();
      a_if.clear = 0; a_if.msb_first = 1; a_if.tx_data = '0; a_if.tx_valid = 0;
      a_if.tx_shift = 0; a_if.ser_in = '0; a_if.rx_shift = 0; a_if.rx_ready = 0;
      b_if.clear = 0; b_if.msb_first = 1; b_if.tx_data = '0; b_if.tx_valid = 0;
      b_if.tx_shift = 0; b_if.ser_in = '0; b_if.rx_shift = 0; b_if.rx_ready = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++; if (a_if.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", a_if.tx_ready); end
      checks++; if (a_if.tx_busy !== 1'b0) begin fails++; $display("FAIL reset_tx_busy: got %b want 0", a_if.tx_busy); end
      checks++; if (a_if.ser_out !== 1'b1) begin fails++; $display("FAIL reset_ser_out: got %b want 1", a_if.ser_out); end
      checks++; if (a_if.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", a_if.rx_valid); end
      checks++; if (a_if.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", a_if.rx_data); end
      checks++; if (a_if.tx_underrun !== 1'b0 || a_if.rx_overrun !== 1'b0) begin
         fails++; $display("FAIL reset_pulses: got %b%b want 00", a_if.tx_underrun, a_if.rx_overrun);
      end
      checks++; if (b_if.ser_out !== 4'hF) begin fails++; $display("FAIL reset_ser_out_b: got %h want f", b_if.ser_out); end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_tx_msb();
      logic [7:0] seq;
      seq = 8'b1010_0101;  // emission order, leftmost first
      a_if.msb_first = 1; a_if.tx_data = 8'hA5; a_if.tx_valid = 1;
      step();
      a_if.tx_valid = 0;
      checks++; if (a_if.tx_busy !== 1'b1) begin fails++; $display("FAIL msb_busy: got %b want 1", a_if.tx_busy); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (a_if.ser_out !== seq[7-i]) begin
            fails++; $display("FAIL msb_unit%0d: got %b want %b", i, a_if.ser_out, seq[7-i]);
         end
         a_if.tx_shift = 1; step(); a_if.tx_shift = 0;
      end
      checks++; if (a_if.ser_out !== 1'b1 || a_if.tx_busy !== 1'b0) begin
         fails++; $display("FAIL msb_idle: got ser_out=%b busy=%b want 1/0", a_if.ser_out, a_if.tx_busy);
      end
   endtask

   task automatic test_tx_lsb();
      logic [7:0] words [2];
      logic [7:0] seqs  [2];
      words[0] = 8'hA5; seqs[0] = 8'b1010_0101;
      words[1] = 8'h1E; seqs[1] = 8'b0111_1000;
      for (int w = 0; w < 2; w++) begin
         a_if.msb_first = 0; a_if.tx_data = words[w]; a_if.tx_valid = 1;
         step();
         a_if.tx_valid = 0;
         a_if.msb_first = 1;  // must not affect the word already loaded
         for (int i = 0; i < 8; i++) begin
            checks++; if (a_if.ser_out !== seqs[w][7-i]) begin
               fails++; $display("FAIL lsb_w%0d_unit%0d: got %b want %b", w, i, a_if.ser_out, seqs[w][7-i]);
            end
            a_if.tx_shift = 1; step(); a_if.tx_shift = 0;
         end
      end
      checks++; if (a_if.tx_busy !== 1'b0) begin fails++; $display("FAIL lsb_idle: got busy=%b want 0", a_if.tx_busy); end
   endtask

   task automatic test_rx_lsb();
      logic [7:0] w;
      w = 8'h3C;
      a_if.msb_first = 0;
      for (int i = 0; i < 8; i++) begin
         a_if.ser_in = w[i]; a_if.rx_shift = 1;
         step();
         a_if.msb_first = 1;  // order latched on the first unit
         if (i == 6) begin
            checks++; if (a_if.rx_valid !== 1'b0) begin fails++; $display("FAIL rx_lsb_early: got valid=%b want 0", a_if.rx_valid); end
         end
      end
      a_if.rx_shift = 0;
      checks++; if (a_if.rx_valid !== 1'b1) begin fails++; $display("FAIL rx_lsb_valid: got %b want 1", a_if.rx_valid); end
      checks++; if (a_if.rx_data !== 8'h3C) begin fails++; $display("FAIL rx_lsb_data: got %h want 3c", a_if.rx_data); end
      a_if.rx_ready = 1; step(); a_if.rx_ready = 0;
      checks++; if (a_if.rx_valid !== 1'b0) begin fails++; $display("FAIL rx_lsb_consume: got %b want 0", a_if.rx_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      exp = 16'h1234;
      a_if.msb_first = 1; a_if.tx_data = 8'h12; a_if.tx_valid = 1;
      step();
      for (int i = 0; i < 16; i++) begin
         checks++; if (a_if.ser_out !== exp[15-i] || a_if.tx_busy !== 1'b1) begin
            fails++; $display("FAIL b2b_unit%0d: got %b busy=%b want %b busy=1", i, a_if.ser_out, a_if.tx_busy, exp[15-i]);
         end
         if (i == 1) begin
            checks++; if (a_if.tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got %b want 0", a_if.tx_ready); end
         end
         if (i == 8) begin
            checks++; if (a_if.tx_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_high: got %b want 1", a_if.tx_ready); end
         end
         a_if.tx_shift = 1; a_if.tx_valid = (i == 0); a_if.tx_data = 8'h34;
         step();
      end
      a_if.tx_shift = 0; a_if.tx_valid = 0;
      checks++; if (a_if.ser_out !== 1'b1 || a_if.tx_busy !== 1'b0) begin
         fails++; $display("FAIL b2b_idle: got ser_out=%b busy=%b want 1/0", a_if.ser_out, a_if.tx_busy);
      end
   endtask

   task automatic test_rx_overrun();
      logic [7:0] w;
      a_if.msb_first = 1; a_if.rx_ready = 0;
      w = 8'h11;
      for (int i = 0; i < 8; i++) begin
         a_if.ser_in = w[7-i]; a_if.rx_shift = 1; step();
      end
      a_if.rx_shift = 0;
      checks++; if (a_if.rx_valid !== 1'b1 || a_if.rx_data !== 8'h11) begin
         fails++; $display("FAIL ovr_first: got valid=%b data=%h want 1/11", a_if.rx_valid, a_if.rx_data);
      end
      checks++; if (a_if.rx_overrun !== 1'b0) begin fails++; $display("FAIL ovr_none: got %b want 0", a_if.rx_overrun); end
      w = 8'h22;
      for (int i = 0; i < 8; i++) begin
         a_if.ser_in = w[7-i]; a_if.rx_shift = 1; step();
      end
      a_if.rx_shift = 0;
      checks++; if (a_if.rx_overrun !== 1'b1) begin fails++; $display("FAIL ovr_pulse: got %b want 1", a_if.rx_overrun); end
      checks++; if (a_if.rx_data !== 8'h11 || a_if.rx_valid !== 1'b1) begin
         fails++; $display("FAIL ovr_hold: got valid=%b data=%h want 1/11", a_if.rx_valid, a_if.rx_data);
      end
      step();
      checks++; if (a_if.rx_overrun !== 1'b0) begin fails++; $display("FAIL ovr_once: got %b want 0", a_if.rx_overrun); end
      a_if.rx_ready = 1; step(); a_if.rx_ready = 0;
      checks++; if (a_if.rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_consume: got %b want 0", a_if.rx_valid); end
   endtask

   task automatic test_unit4();
      logic [15:0] w;
      w = 16'hBEEF;
      b_if.msb_first = 1; b_if.tx_data = w; b_if.tx_valid = 1;
      step();
      b_if.tx_valid = 0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (b_if.ser_out !== w[15-4*i -: 4]) begin
            fails++; $display("FAIL u4_unit%0d: got %h want %h", i, b_if.ser_out, w[15-4*i -: 4]);
         end
         b_if.tx_shift = 1; step(); b_if.tx_shift = 0;
      end
      checks++; if (b_if.tx_busy !== 1'b0 || b_if.ser_out !== 4'hF) begin
         fails++; $display("FAIL u4_idle: got busy=%b ser_out=%h want 0/f", b_if.tx_busy, b_if.ser_out);
      end
      checks++; if (b_if.tx_underrun !== 1'b0) begin fails++; $display("FAIL u4_no_underrun: got %b want 0", b_if.tx_underrun); end
      b_if.tx_shift = 1; step(); b_if.tx_shift = 0;
      checks++; if (b_if.tx_underrun !== 1'b1) begin fails++; $display("FAIL u4_underrun: got %b want 1", b_if.tx_underrun); end
      step();
      checks++; if (b_if.tx_underrun !== 1'b0) begin fails++; $display("FAIL u4_underrun_once: got %b want 0", b_if.tx_underrun); end
   endtask

   task automatic test_clear();
      logic [7:0] w;
      a_if.msb_first = 1;
      a_if.tx_data = 8'h0F; a_if.tx_valid = 1; step();
      a_if.tx_data = 8'hF0; step();
      a_if.tx_valid = 0;
      a_if.tx_shift = 1; step(); step(); a_if.tx_shift = 0;
      checks++; if (a_if.tx_ready !== 1'b0 || a_if.tx_busy !== 1'b1) begin
         fails++; $display("FAIL clr_setup: got ready=%b busy=%b want 0/1", a_if.tx_ready, a_if.tx_busy);
      end
      for (int i = 0; i < 3; i++) begin
         a_if.ser_in = 1'b1; a_if.rx_shift = 1; step();
      end
      a_if.rx_shift = 0;
      a_if.clear = 1; step(); a_if.clear = 0;
      checks++; if (a_if.tx_ready !== 1'b1 || a_if.tx_busy !== 1'b0 || a_if.ser_out !== 1'b1) begin
         fails++; $display("FAIL clr_tx: got ready=%b busy=%b ser_out=%b want 1/0/1", a_if.tx_ready, a_if.tx_busy, a_if.ser_out);
      end
      checks++; if (a_if.rx_valid !== 1'b0 || a_if.rx_data !== 8'h00) begin
         fails++; $display("FAIL clr_rx: got valid=%b data=%h want 0/00", a_if.rx_valid, a_if.rx_data);
      end
      a_if.tx_shift = 1; step(); a_if.tx_shift = 0;
      checks++; if (a_if.tx_underrun !== 1'b1) begin fails++; $display("FAIL clr_hold_dropped: got underrun=%b want 1", a_if.tx_underrun); end
      w = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         a_if.ser_in = w[7-i]; a_if.rx_shift = 1; step();
      end
      a_if.rx_shift = 0;
      checks++; if (a_if.rx_valid !== 1'b1 || a_if.rx_data !== 8'h5A) begin
         fails++; $display("FAIL clr_rx_next: got valid=%b data=%h want 1/5a", a_if.rx_valid, a_if.rx_data);
      end
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_tx_msb();
      test_tx_lsb();
      test_rx_lsb();
      test_back_to_back();
      test_rx_overrun();
      test_unit4();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
